// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: data/address widths, buffer depth, load FSM states.
// Used by the image loader and by the pool/conv layer blocks.
`timescale 1ns/1ps
package cnn_pkg;

    localparam int DATA_SZ = 16;
    localparam int ADDR_SZ = 16;
    localparam int DEPTH   = 1024;
    localparam int PROD_W  = 2 * DATA_SZ;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int IDX_W   = $clog2(DEPTH);

    typedef logic signed [DATA_SZ-1:0] word_t;
    typedef logic        [ADDR_SZ-1:0] addr_t;
    typedef logic        [CNT_W-1:0]   cnt_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} load_state_t;

    // Word count of a square image; the full-width product never overflows.
    function automatic logic [PROD_W-1:0] word_count(input logic [DATA_SZ-1:0] side);
        return PROD_W'(side) * PROD_W'(side);
    endfunction

endpackage

// File: rtl/image_load_block_if.sv
// Layer load request/response signals plus the memory read port of the image loader.
`timescale 1ns/1ps
interface image_load_block_if;
    import cnn_pkg::*;

    logic                 loadEnable;
    addr_t                loadAddr;
    logic [DATA_SZ-1:0]   loadSize;
    word_t                loadOut [0:DEPTH-1];
    logic                 loadDone;
    logic                 loadBusy;
    logic                 sizeErr;

    logic                 memRead;
    addr_t                memAddr;
    word_t                memData;
    logic                 memValid;

    // Layer FSM side: issues requests, consumes the buffer.
    modport master (
        output loadEnable, loadAddr, loadSize,
        input  loadOut, loadDone, loadBusy, sizeErr
    );

    // Image loader: answers load requests and drives the memory read port.
    modport slave (
        input  loadEnable, loadAddr, loadSize, memData, memValid,
        output loadOut, loadDone, loadBusy, sizeErr, memRead, memAddr
    );

    // Shared data memory read port.
    modport mem (
        input  memRead, memAddr,
        output memData, memValid
    );

endinterface

// File: rtl/image_load_block.sv
// Image loader: fetches loadSize*loadSize words, one read outstanding, into a parallel buffer.
// Build option LOADER_ZERO_FILL_EN clears the whole buffer when a load is accepted.
`timescale 1ns/1ps
module image_load_block
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    image_load_block_if.slave bus
);

    load_state_t state_q, state_d;
    addr_t       base_q, base_d;
    cnt_t        num_q, num_d;
    cnt_t        idx_q, idx_d;
    logic        mem_read_q, mem_read_d;
    addr_t       mem_addr_q, mem_addr_d;
    logic        load_done_q, load_done_d;
    logic        load_busy_q, load_busy_d;
    logic        size_err_q, size_err_d;
    logic        buf_we;
    logic [PROD_W-1:0] n_full;
    logic        n_over;

    word_t load_buf_q [0:DEPTH-1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        idx_d       = idx_q;
        mem_read_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        load_done_d = 1'b0;
        load_busy_d = load_busy_q;
        size_err_d  = size_err_q;
        buf_we      = 1'b0;
        n_full      = word_count(bus.loadSize);
        n_over      = n_full > PROD_W'(DEPTH);

        unique case (state_q)
            IDLE: begin
                if (bus.loadEnable) begin
                    base_d      = bus.loadAddr;
                    idx_d       = '0;
                    load_busy_d = 1'b1;
                    size_err_d  = n_over;
                    num_d       = n_over ? cnt_t'(DEPTH) : cnt_t'(n_full);
                    if (num_d == '0) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        mem_read_d = 1'b1;
                        mem_addr_d = bus.loadAddr;
                    end
                end
            end
            // The read strobe for this word is already on the bus; only abort is decided here.
            ISSUE: state_d = bus.loadEnable ? WAIT : DRAIN;
            WAIT: begin
                if (!bus.loadEnable) begin
                    // Data arriving together with the abort completes the only read in flight.
                    if (bus.memValid) begin
                        state_d     = IDLE;
                        load_busy_d = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (bus.memValid) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + cnt_t'(1);
                    if (idx_d == num_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        mem_read_d = 1'b1;
                        mem_addr_d = base_q + addr_t'(idx_d);
                    end
                end
            end
            DRAIN: begin
                if (bus.memValid) begin
                    state_d     = IDLE;
                    load_busy_d = 1'b0;
                end
            end
            DONE: begin
                state_d     = IDLE;
                load_busy_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            load_done_q <= 1'b0;
            load_busy_q <= 1'b0;
            size_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            mem_read_q  <= mem_read_d;
            mem_addr_q  <= mem_addr_d;
            load_done_q <= load_done_d;
            load_busy_q <= load_busy_d;
            size_err_q  <= size_err_d;
        end
    end

    // NOTE: the buffer is built from resettable flops, not a RAM, because reset must zero every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) load_buf_q[i] <= '0;
        end else begin
`ifdef LOADER_ZERO_FILL_EN
            if (state_q == IDLE && bus.loadEnable) begin
                for (int i = 0; i < DEPTH; i++) load_buf_q[i] <= '0;
            end else if (buf_we) begin
                load_buf_q[idx_q[IDX_W-1:0]] <= bus.memData;
            end
`else
            if (buf_we) begin
                load_buf_q[idx_q[IDX_W-1:0]] <= bus.memData;
            end
`endif
        end
    end

    assign bus.loadOut  = load_buf_q;
    assign bus.loadDone = load_done_q;
    assign bus.loadBusy = load_busy_q;
    assign bus.sizeErr  = size_err_q;
    assign bus.memRead  = mem_read_q;
    assign bus.memAddr  = mem_addr_q;

endmodule

// File: tb/tb_image_load_block.sv
// Self-checking bench for image_load_block: variable-latency memory model plus reference buffer.
// Honours LOADER_ZERO_FILL_EN the same way as the design build.
`timescale 1ns/1ps
module tb_image_load_block;
    import cnn_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    image_load_block_if bus();

    image_load_block dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents are a fixed scramble of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        return 16'(addr * 16'd40503) ^ 16'h5A5A;
    endfunction

    function automatic int model_count(input logic [15:0] side);
        longint p;
        p = longint'(side) * longint'(side);
        return (p > DEPTH) ? DEPTH : int'(p);
    endfunction

    // Memory model: answers each read 1..4 cycles later (or a fixed latency when set).
    int          mem_lat_fixed = 0;
    int          lat_pick;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr;
    logic [15:0] read_q[$];
    int          lat_q[$];

    always @(negedge clk) begin
        bus.memValid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.memValid = 1'b1;
                bus.memData  = word_t'(mem_word(pend_addr));
                pend         = 1'b0;
            end
        end
        if (bus.memRead === 1'b1) begin
            lat_pick  = (mem_lat_fixed != 0) ? mem_lat_fixed : int'($urandom_range(4, 1));
            pend      = 1'b1;
            pend_cnt  = lat_pick;
            pend_addr = bus.memAddr;
            read_q.push_back(bus.memAddr);
            lat_q.push_back(lat_pick);
        end
    end

    int done_count = 0;
    int busy_count = 0;
    always @(negedge clk) begin
        if (bus.loadDone === 1'b1) done_count++;
        if (bus.loadBusy === 1'b1) busy_count++;
    end

    logic [15:0] model_buf [DEPTH];

    task automatic model_accept();
`ifdef LOADER_ZERO_FILL_EN
        for (int i = 0; i < DEPTH; i++) model_buf[i] = 16'h0;
`endif
    endtask

    task automatic check_buf(input string name);
        int          mism;
        logic [15:0] v;
        mism = 0;
        for (int i = 0; i < DEPTH; i++) begin
            v = bus.loadOut[i];
            if (v !== model_buf[i]) mism++;
        end
        check(name, mism, 0);
    endtask

    // One complete load: request, wait for loadDone (bounded), then check everything observable.
    task automatic run_load(input logic [15:0] addr, input logic [15:0] side,
                            input int exp_n, input bit exp_err, input string tag);
        int cycles, lat_sum, mism, done0, busy0;
        bit seen;
        read_q.delete();
        lat_q.delete();
        done0 = done_count;
        busy0 = busy_count;
        @(negedge clk);
        bus.loadAddr   = addr;
        bus.loadSize   = side;
        bus.loadEnable = 1'b1;
        model_accept();
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 8000) begin
            @(negedge clk);
            cycles++;
            if (bus.loadDone === 1'b1) seen = 1'b1;
        end
        bus.loadEnable = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        repeat (3) @(negedge clk);

        for (int i = 0; i < exp_n; i++) model_buf[i] = mem_word(addr + 16'(i));
        lat_sum = 0;
        foreach (lat_q[i]) lat_sum += lat_q[i] + 1;
        mism = 0;
        foreach (read_q[i]) if (read_q[i] !== addr + 16'(i)) mism++;

        check({tag, "_reads"},     read_q.size(), exp_n);
        check({tag, "_addr_seq"},  mism, 0);
        check({tag, "_done_cnt"},  done_count - done0, 1);
        check({tag, "_latency"},   cycles + 1, lat_sum + 2);
        check({tag, "_busy_cyc"},  busy_count - busy0, lat_sum + 1);
        check({tag, "_size_err"},  bus.sizeErr, exp_err);
        check({tag, "_busy_end"},  bus.loadBusy, 0);
        check_buf({tag, "_buffer"});
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] side;
        int          exp_n;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, done0, mism;
        logic [15:0] side, addr;

        vecs[0] = '{16'h0100, 16'd3,      9,    1'b0};
        vecs[1] = '{16'h0040, 16'd0,      0,    1'b0};
        vecs[2] = '{16'h2000, 16'd33,     1024, 1'b1};
        vecs[3] = '{16'hFFFE, 16'd2,      4,    1'b0};
        vecs[4] = '{16'h0500, 16'd32,     1024, 1'b0};
        vecs[5] = '{16'h1234, 16'd1,      1,    1'b0};
        vecs[6] = '{16'h7000, 16'h0100,   1024, 1'b1};
        vecs[7] = '{16'h3000, 16'hFFFF,   1024, 1'b1};

        for (int i = 0; i < DEPTH; i++) model_buf[i] = 16'h0;
        bus.loadEnable = 1'b0;
        bus.loadAddr   = '0;
        bus.loadSize   = '0;

        repeat (3) @(negedge clk);
        check("rst_busy",    bus.loadBusy, 0);
        check("rst_done",    bus.loadDone, 0);
        check("rst_size_err", bus.sizeErr, 0);
        check("rst_mem_read", bus.memRead, 0);
        check("rst_mem_addr", bus.memAddr, 0);
        check_buf("rst_buffer");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i])
            run_load(vecs[i].addr, vecs[i].side, vecs[i].exp_n, vecs[i].exp_err,
                     $sformatf("vec%0d", i));

        for (int k = 0; k < 6; k++) begin
            side = 16'($urandom_range(12, 0));
            addr = 16'($urandom);
            run_load(addr, side, model_count(side), 1'b0, $sformatf("rnd%0d", k));
        end

        // Abort after the 4th read of a size-4 load; the 4th word must be drained and discarded.
        read_q.delete();
        lat_q.delete();
        done0 = done_count;
        @(negedge clk);
        bus.loadAddr   = 16'h0800;
        bus.loadSize   = 16'd4;
        bus.loadEnable = 1'b1;
        model_accept();
        r = 0;
        c = 0;
        while (r < 4 && c < 200) begin
            @(negedge clk);
            c++;
            if (bus.memRead === 1'b1) r++;
        end
        bus.loadEnable = 1'b0;
        check("abort_reached_4th", r, 4);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) model_buf[i] = mem_word(16'h0800 + 16'(i));
        check("abort_reads",   read_q.size(), 4);
        check("abort_no_done", done_count - done0, 0);
        check("abort_idle",    bus.loadBusy, 0);
        check_buf("abort_buffer");
        run_load(16'h0900, 16'd2, 4, 1'b0, "post_abort");

        // Reset in the middle of a wait: outputs clear at once and the late data is ignored.
        mem_lat_fixed = 4;
        done0 = done_count;
        @(negedge clk);
        bus.loadAddr   = 16'h4000;
        bus.loadSize   = 16'd40;
        bus.loadEnable = 1'b1;
        c = 0;
        while (bus.memRead !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("rst_mid_issue_seen", bus.memRead, 1);
        @(negedge clk);
        check("rst_mid_size_err_pre", bus.sizeErr, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_busy",     bus.loadBusy, 0);
        check("rst_mid_size_err", bus.sizeErr, 0);
        check("rst_mid_mem_read", bus.memRead, 0);
        check("rst_mid_mem_addr", bus.memAddr, 0);
        check("rst_mid_done",     bus.loadDone, 0);
        for (int i = 0; i < DEPTH; i++) model_buf[i] = 16'h0;
        check_buf("rst_mid_buffer");
        bus.loadEnable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_late_pending", pend, 0);
        check("rst_late_busy",    bus.loadBusy, 0);
        check("rst_late_no_done", done_count - done0, 0);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (bus.loadOut[i] !== '0) mism++;
        check("rst_late_buffer", mism, 0);
        mem_lat_fixed = 0;

        run_load(16'h0100, 16'd3, 9, 1'b0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
